// File: rtl/mul_div_unit_pkg.sv
// Shared op codes, FSM states and helpers for the multiply/divide unit.
package mul_div_unit_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      MDU_MULT  = 2'b00,
      MDU_MULTU = 2'b01,
      MDU_DIV   = 2'b10,
      MDU_DIVU  = 2'b11
   } mdu_op_e;

   typedef enum logic [2:0] {
      MDU_S_IDLE = 3'd0,
      MDU_S_MUL  = 3'd1,
      MDU_S_DIV  = 3'd2,
      MDU_S_FIX  = 3'd3,
      MDU_S_DONE = 3'd4
   } mdu_state_e;

   // Magnitude of a value, treating it as two's complement only when sgn is set.
   // -32'h80000000 wraps to itself, which is the correct unsigned 2^31.
   function automatic logic [DATA_W-1:0] mdu_mag(input logic [DATA_W-1:0] v, input logic sgn);
      return (sgn && v[DATA_W-1]) ? -v : v;
   endfunction

endpackage

// File: rtl/mdu_divider.sv
// Iterative restoring radix-2 divider core on unsigned magnitudes.
module mdu_divider
   import mul_div_unit_pkg::*;
#(
   parameter int DIV_CYCLES = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  step,
   input  logic [DIV_CYCLES-1:0] dividend,
   input  logic [DIV_CYCLES-1:0] divisor,
   output logic [DIV_CYCLES-1:0] quot,
   output logic [DIV_CYCLES-1:0] rem,
   output logic                  last
);

   localparam int W  = DIV_CYCLES;
   localparam int CW = (W > 1) ? $clog2(W) : 1;

   logic [2*W-1:0] acc;    // {remainder, quotient}
   logic [W-1:0]   dvsr;
   logic [CW-1:0]  cnt;
   logic [W:0]     diff;

   // Trial subtract on the upper W+1 bits of the shifted accumulator.
   assign diff = acc[2*W-1:W-1] - {1'b0, dvsr};
   assign quot = acc[W-1:0];
   assign rem  = acc[2*W-1:W];
   assign last = (cnt == CW'(W-1));

   // One quotient bit per step; keep the difference when it did not go negative.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc  <= '0;
         dvsr <= '0;
         cnt  <= '0;
      end else if (load) begin
         acc  <= {{W{1'b0}}, dividend};
         dvsr <= divisor;
         cnt  <= '0;
      end else if (step) begin
         cnt <= cnt + 1'b1;
         if (!diff[W])
            acc <= {diff[W-1:0], acc[W-2:0], 1'b1};
         else
            acc <= {acc[2*W-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit feeding the HI/LO write ports.
module mul_div_unit
   import mul_div_unit_pkg::*;
#(
   parameter int DIV_CYCLES = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic [1:0]  op_i,
   input  logic [31:0] opa_i,
   input  logic [31:0] opb_i,
   input  logic        cancel_i,
   output logic        busy_o,
   output logic        hi_we_o,
   output logic [31:0] hi_o,
   output logic        lo_we_o,
   output logic [31:0] lo_o
);

   mdu_state_e  state;
   mdu_op_e     op_q;
   logic [31:0] opa_q, opb_q;
   logic        neg_quot_q, neg_rem_q;
   logic        busy_q, we_q;
   logic [31:0] hi_q, lo_q;

   logic        sgn_in;
   logic [31:0] mag_a, mag_b;
   logic        div_load, div_last;
   logic [31:0] div_quot, div_rem;
   logic [63:0] ext_a, ext_b, prod;

   // Signed DIV works on magnitudes; signs are reapplied in FIX.
   assign sgn_in   = (op_i == MDU_DIV);
   assign mag_a    = mdu_mag(opa_i, sgn_in);
   assign mag_b    = mdu_mag(opb_i, sgn_in);
   assign div_load = (state == MDU_S_IDLE) && start_i && !cancel_i && op_i[1] && (opb_i != '0);

   // Extending to 64 bits makes the low 64 product bits correct for both signednesses.
   assign ext_a = {{32{(op_q == MDU_MULT) & opa_q[31]}}, opa_q};
   assign ext_b = {{32{(op_q == MDU_MULT) & opb_q[31]}}, opb_q};
   assign prod  = ext_a * ext_b;

   mdu_divider #(.DIV_CYCLES(DIV_CYCLES)) u_div (
      .clk      (clk),
      .rst      (rst),
      .load     (div_load),
      .step     (state == MDU_S_DIV),
      .dividend (mag_a),
      .divisor  (mag_b),
      .quot     (div_quot),
      .rem      (div_rem),
      .last     (div_last)
   );

   // Control FSM; results land in hi_q/lo_q only on the edge entering DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= MDU_S_IDLE;
         op_q       <= MDU_MULT;
         opa_q      <= '0;
         opb_q      <= '0;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         busy_q     <= 1'b0;
         we_q       <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else if (cancel_i) begin
         state  <= MDU_S_IDLE;
         busy_q <= 1'b0;
         we_q   <= 1'b0;
      end else begin
         case (state)
            MDU_S_IDLE: begin
               if (start_i) begin
                  op_q       <= mdu_op_e'(op_i);
                  opa_q      <= opa_i;
                  opb_q      <= opb_i;
                  neg_quot_q <= sgn_in & (opa_i[31] ^ opb_i[31]);
                  neg_rem_q  <= sgn_in & opa_i[31];
                  busy_q     <= 1'b1;
                  if (!op_i[1]) begin
                     state <= MDU_S_MUL;
                  end else if (opb_i == '0) begin
                     hi_q  <= opa_i;
                     lo_q  <= '1;
                     we_q  <= 1'b1;
                     state <= MDU_S_DONE;
                  end else begin
                     state <= MDU_S_DIV;
                  end
               end
            end
            MDU_S_MUL: begin
               hi_q  <= prod[63:32];
               lo_q  <= prod[31:0];
               we_q  <= 1'b1;
               state <= MDU_S_DONE;
            end
            MDU_S_DIV: begin
               if (div_last) state <= MDU_S_FIX;
            end
            MDU_S_FIX: begin
               lo_q  <= neg_quot_q ? -div_quot : div_quot;
               hi_q  <= neg_rem_q  ? -div_rem  : div_rem;
               we_q  <= 1'b1;
               state <= MDU_S_DONE;
            end
            MDU_S_DONE: begin
               we_q   <= 1'b0;
               busy_q <= 1'b0;
               state  <= MDU_S_IDLE;
            end
            default: begin
               we_q   <= 1'b0;
               busy_q <= 1'b0;
               state  <= MDU_S_IDLE;
            end
         endcase
      end
   end

   // A flush arriving during DONE must suppress the write in the same cycle.
   assign busy_o  = busy_q;
   assign hi_we_o = we_q & ~cancel_i;
   assign lo_we_o = we_q & ~cancel_i;
   assign hi_o    = hi_q;
   assign lo_o    = lo_q;

endmodule
